// File: rtl/layer_mux_pkg.sv
// -----------------------------------------------------------------------------
// layer_mux_pkg
// Shared constants and helpers for the layer priority mux:
//   - RGB332 field positions and the 8-bit colour width
//   - default transparent colour key
//   - layer-index constant reported when no layer wins
//   - rgb888_t output struct and the RGB332 -> RGB888 expansion helper
// -----------------------------------------------------------------------------
package layer_mux_pkg;

  localparam int RGB_W   = 8;

  // RGB332 field positions: rrr_ggg_bb
  localparam int RED_MSB = 7;
  localparam int RED_LSB = 5;
  localparam int GRN_MSB = 4;
  localparam int GRN_LSB = 2;
  localparam int BLU_MSB = 1;
  localparam int BLU_LSB = 0;

  // Colour key meaning "this layer is not drawing here"
  localparam logic [RGB_W-1:0] TRANSPARENT_RGB_DEFAULT = 8'hFF;

  // Index reported on winLayer whenever the background (or blanking) is shown
  localparam int NO_LAYER_IDX = 0;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  // Bit-replicating expansion so full-scale fields map to 8'hFF and zero to 8'h00
  function automatic rgb888_t expand_rgb332(input logic [RGB_W-1:0] c);
    rgb888_t x;
    x.red   = {c[RED_MSB:RED_LSB], c[RED_MSB:RED_LSB], c[RED_MSB:RED_MSB-1]};
    x.green = {c[GRN_MSB:GRN_LSB], c[GRN_MSB:GRN_LSB], c[GRN_MSB:GRN_MSB-1]};
    x.blue  = {4{c[BLU_MSB:BLU_LSB]}};
    return x;
  endfunction

endpackage

// File: rtl/layer_prio_enc.sv
// -----------------------------------------------------------------------------
// layer_prio_enc
// Combinational lowest-index-first priority encoder.
// Ports:
//   req   [NUM_LAYERS-1:0]  request vector, bit 0 has highest priority
//   any                     at least one request bit is set
//   index [IDX_W-1:0]       index of the lowest set bit (NO_LAYER_IDX if none)
// -----------------------------------------------------------------------------
module layer_prio_enc
  import layer_mux_pkg::*;
#(
  parameter  int NUM_LAYERS = 16,
  localparam int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] req,
  output logic                  any,
  output logic [IDX_W-1:0]      index
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    any   = |req;
    index = IDX_W'(NO_LAYER_IDX);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      index = req[i] ? IDX_W'(i) : index;
    end
  end

endmodule

// File: rtl/layer_priority_mux.sv
// -----------------------------------------------------------------------------
// layer_priority_mux
// Two-stage pixel compositor: picks the lowest-index drawing layer (or the
// background), expands RGB332 to 24-bit colour and tracks per-frame overlap.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   drawReq[N]            per-layer draw request for the current pixel
//   layerRGB[N*8]         per-layer RGB332 colour, layer i at [i*8 +: 8]
//   layerEnable[N]        per-layer enable mask (0 hides the layer)
//   backGroundRGB[8]      colour shown when no layer qualifies
//   pixelValid            visible-area qualifier
//   startOfFrame          one-cycle pulse on the first pixel of a frame
//   redOut/greenOut/blueOut  expanded colour, 2 cycles after the inputs
//   winValid, winLayer    output pixel came from a layer / which one
//   overlapLive[N]        sticky overlap flags for the frame in progress
//   overlapFrame[N]       overlap flags of the last completed frame
// -----------------------------------------------------------------------------
module layer_priority_mux
  import layer_mux_pkg::*;
#(
  parameter int               NUM_LAYERS      = 16,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB = TRANSPARENT_RGB_DEFAULT,
  parameter int               IDX_W           = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [RGB_W-1:0]            backGroundRGB,
  input  logic                        pixelValid,
  input  logic                        startOfFrame,
  output logic [7:0]                  redOut,
  output logic [7:0]                  greenOut,
  output logic [7:0]                  blueOut,
  output logic                        winValid,
  output logic [IDX_W-1:0]            winLayer,
  output logic [NUM_LAYERS-1:0]       overlapLive,
  output logic [NUM_LAYERS-1:0]       overlapFrame
);

  localparam int ENC_W = $clog2(NUM_LAYERS);

  logic [NUM_LAYERS-1:0]       qual_s;
  logic [NUM_LAYERS-1:0]       qual_r;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_r;
  logic [RGB_W-1:0]            bg_r;
  logic                        pix_valid_r;

  logic                        win_any_s;
  logic [ENC_W-1:0]            win_idx_s;
  logic [RGB_W-1:0]            sel_rgb_s;
  logic                        sel_valid_s;
  logic [IDX_W-1:0]            sel_idx_s;
  rgb888_t                     px_s;

  logic [7:0]                  red_r;
  logic [7:0]                  green_r;
  logic [7:0]                  blue_r;
  logic                        win_valid_r;
  logic [IDX_W-1:0]            win_layer_r;

  logic [NUM_LAYERS-1:0]       ovl_set_s;
  logic [NUM_LAYERS-1:0]       ovl_live_r;
  logic [NUM_LAYERS-1:0]       ovl_frame_r;

  // A layer takes part only if requested, enabled and not keyed transparent
  always_comb begin
    qual_s = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      qual_s[i] = drawReq[i] & layerEnable[i] &
                  (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT_RGB);
    end
  end

  // Stage 1: capture qualify vector, colours and pixel valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qual_r      <= '0;
      rgb_r       <= '0;
      bg_r        <= 8'h00;
      pix_valid_r <= 1'b0;
    end else begin
      qual_r      <= qual_s;
      rgb_r       <= layerRGB;
      bg_r        <= backGroundRGB;
      pix_valid_r <= pixelValid;
    end
  end

  layer_prio_enc #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_prio_enc (
    .req   (qual_r),
    .any   (win_any_s),
    .index (win_idx_s)
  );

  // Winner / background / blanking selection for stage 2
  always_comb begin
    sel_rgb_s   = 8'h00;
    sel_valid_s = 1'b0;
    sel_idx_s   = IDX_W'(NO_LAYER_IDX);
    if (!pix_valid_r) begin
      sel_rgb_s   = 8'h00;
      sel_valid_s = 1'b0;
      sel_idx_s   = IDX_W'(NO_LAYER_IDX);
    end else if (win_any_s) begin
      sel_rgb_s   = rgb_r[win_idx_s*RGB_W +: RGB_W];
      sel_valid_s = 1'b1;
      sel_idx_s   = IDX_W'(win_idx_s);
    end else begin
      sel_rgb_s   = bg_r;
      sel_valid_s = 1'b0;
      sel_idx_s   = IDX_W'(NO_LAYER_IDX);
    end
  end

  assign px_s = expand_rgb332(sel_rgb_s);

  // Stage 2: registered expanded colour and winner information
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_r       <= 8'h00;
      green_r     <= 8'h00;
      blue_r      <= 8'h00;
      win_valid_r <= 1'b0;
      win_layer_r <= '0;
    end else begin
      red_r       <= px_s.red;
      green_r     <= px_s.green;
      blue_r      <= px_s.blue;
      win_valid_r <= sel_valid_s;
      win_layer_r <= sel_idx_s;
    end
  end

  // Layer i overlaps when some lower-index layer also qualifies on a visible pixel
  always_comb begin : ovl_comb
    logic lower_any;
    lower_any = 1'b0;
    ovl_set_s = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      ovl_set_s[i] = pix_valid_r & qual_r[i] & lower_any;
      lower_any    = lower_any | qual_r[i];
    end
  end

  // Overlap flags: frame pulse snapshots live (plus pending sets) and clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovl_live_r  <= '0;
      ovl_frame_r <= '0;
    end else if (startOfFrame) begin
      ovl_frame_r <= ovl_live_r | ovl_set_s;
      ovl_live_r  <= '0;
    end else begin
      ovl_frame_r <= ovl_frame_r;
      ovl_live_r  <= ovl_live_r | ovl_set_s;
    end
  end

  assign redOut       = red_r;
  assign greenOut     = green_r;
  assign blueOut      = blue_r;
  assign winValid     = win_valid_r;
  assign winLayer     = win_layer_r;
  assign overlapLive  = ovl_live_r;
  assign overlapFrame = ovl_frame_r;

endmodule

// File: tb/tb_layer_priority_mux.sv
// -----------------------------------------------------------------------------
// tb_layer_priority_mux
// Scoreboard bench: the driver computes the expected pixel and overlap state
// from the compositing rules and queues them with the cycle they are due; an
// independent negedge monitor pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_layer_priority_mux;

  localparam int NL = 16;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NL-1:0]   drawReq;
  logic [NL*8-1:0] layerRGB;
  logic [NL-1:0]   layerEnable;
  logic [7:0]      backGroundRGB;
  logic            pixelValid;
  logic            startOfFrame;
  logic [7:0]      redOut, greenOut, blueOut;
  logic            winValid;
  logic [IW-1:0]   winLayer;
  logic [NL-1:0]   overlapLive, overlapFrame;

  layer_priority_mux #(.NUM_LAYERS(NL)) dut (
    .clk           (clk),
    .reset         (reset),
    .drawReq       (drawReq),
    .layerRGB      (layerRGB),
    .layerEnable   (layerEnable),
    .backGroundRGB (backGroundRGB),
    .pixelValid    (pixelValid),
    .startOfFrame  (startOfFrame),
    .redOut        (redOut),
    .greenOut      (greenOut),
    .blueOut       (blueOut),
    .winValid      (winValid),
    .winLayer      (winLayer),
    .overlapLive   (overlapLive),
    .overlapFrame  (overlapFrame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    r, g, b;
    logic          v;
    logic [IW-1:0] l;
    int            due;
  } pix_t;

  typedef struct {
    logic [NL-1:0] live, frame;
    int            due;
  } ovl_t;

  pix_t pix_q[$];
  ovl_t ovl_q[$];
  pix_t mon_pix;
  ovl_t mon_ovl;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference overlap state (frame-level bookkeeping)
  logic [NL-1:0] m_live, m_frame, m_pending;

  logic [NL-1:0]   rq, en;
  logic [NL*8-1:0] rgb;
  logic            pv, sof, next_sof;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 3-bit level to 8 bits: nearest of v*255/7
  function automatic logic [7:0] widen3(input int v);
    return 8'((v * 255 + 3) / 7);
  endfunction

  // Apply one pixel, queue its expected result, advance one clock
  task automatic drive_pixel(input logic [NL-1:0] req, input logic [NL-1:0] ena,
                             input logic [NL*8-1:0] cols, input logic [7:0] bg,
                             input logic valid, input logic frame_start);
    pix_t          e;
    ovl_t          o;
    int            win;
    logic [NL-1:0] ovl;
    logic [7:0]    c;
    drawReq       = req;
    layerEnable   = ena;
    layerRGB      = cols;
    backGroundRGB = bg;
    pixelValid    = valid;
    startOfFrame  = frame_start;
    win = -1;
    ovl = '0;
    // every drawing layer other than the winner is an overlapping one
    for (int i = 0; i < NL; i++) begin
      if (req[i] && ena[i] && cols[i*8 +: 8] != 8'hFF) begin
        if (win < 0) win = i;
        else ovl[i] = valid;
      end
    end
    if (!valid) begin
      c = 8'h00; e.v = 1'b0; e.l = '0;
    end else if (win >= 0) begin
      c = cols[win*8 +: 8]; e.v = 1'b1; e.l = IW'(win);
    end else begin
      c = bg; e.v = 1'b0; e.l = '0;
    end
    e.r   = widen3(int'(c[7:5]));
    e.g   = widen3(int'(c[4:2]));
    e.b   = 8'(int'(c[1:0]) * 85);
    e.due = cyc + 2;
    pix_q.push_back(e);
    @(posedge clk);
    #1;
    // the pixel one step ahead in the pipe contributes to the frame being closed
    if (frame_start) begin
      m_frame = m_live | m_pending;
      m_live  = '0;
    end else begin
      m_live  = m_live | m_pending;
    end
    m_pending = ovl;
    o.live  = m_live;
    o.frame = m_frame;
    o.due   = cyc;
    ovl_q.push_back(o);
  endtask

  task automatic idle(input logic frame_start);
    drive_pixel({NL{1'b0}}, {NL{1'b1}}, {NL*8{1'b0}}, 8'h00, 1'b1, frame_start);
  endtask

  task automatic check_pixel(input string tag, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic v, input int l);
    check({tag, "_red"},   32'(redOut),   32'(r));
    check({tag, "_green"}, 32'(greenOut), 32'(g));
    check({tag, "_blue"},  32'(blueOut),  32'(b));
    check({tag, "_valid"}, 32'(winValid), 32'(v));
    check({tag, "_layer"}, 32'(winLayer), 32'(l));
  endtask

  task automatic check_all_zero(input string tag);
    check_pixel(tag, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    check({tag, "_live"},  32'(overlapLive),  32'h0);
    check({tag, "_frame"}, 32'(overlapFrame), 32'h0);
  endtask

  task automatic pulse_reset(input int hold);
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    pix_q.delete();
    ovl_q.delete();
    repeat (hold) @(posedge clk);
    #1;
    reset     = 1'b0;
    m_live    = '0;
    m_frame   = '0;
    m_pending = '0;
  endtask

  task automatic rand_pixel();
    for (int i = 0; i < NL; i++) begin
      rq[i] = ($urandom_range(0, 3) == 0);
      en[i] = ($urandom_range(0, 6) != 0);
      rgb[i*8 +: 8] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
    end
    pv       = ($urandom_range(0, 9) != 0);
    sof      = next_sof;
    next_sof = 1'b0;
    if ($urandom_range(0, 39) == 0) begin
      sof      = 1'b1;
      next_sof = ($urandom_range(0, 3) == 0);
    end
    drive_pixel(rq, en, rgb, 8'($urandom), pv, sof);
  endtask

  // Monitor: compare every queued expectation in the cycle it falls due
  always @(negedge clk) begin
    if (!reset) begin
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        mon_pix = pix_q.pop_front();
        check("sb_red",      32'(redOut),   32'(mon_pix.r));
        check("sb_green",    32'(greenOut), 32'(mon_pix.g));
        check("sb_blue",     32'(blueOut),  32'(mon_pix.b));
        check("sb_winValid", 32'(winValid), 32'(mon_pix.v));
        check("sb_winLayer", 32'(winLayer), 32'(mon_pix.l));
      end
      while (ovl_q.size() > 0 && ovl_q[0].due <= cyc) begin
        mon_ovl = ovl_q.pop_front();
        check("sb_overlapLive",  32'(overlapLive),  32'(mon_ovl.live));
        check("sb_overlapFrame", 32'(overlapFrame), 32'(mon_ovl.frame));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    drawReq       = '0;
    layerRGB      = '0;
    layerEnable   = '0;
    backGroundRGB = 8'h00;
    pixelValid    = 1'b0;
    startOfFrame  = 1'b0;
    next_sof      = 1'b0;
    m_live        = '0;
    m_frame       = '0;
    m_pending     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Layers 3 and 7 draw, layer 3 wins with pure red
    en  = {NL{1'b1}};
    rq  = 16'h0088;
    rgb = {NL*8{1'b0}};
    rgb[3*8 +: 8] = 8'hE0;
    rgb[7*8 +: 8] = 8'h1C;
    drive_pixel(rq, en, rgb, 8'h03, 1'b1, 1'b0);
    idle(1'b0);
    check_pixel("l3_wins", 8'hFF, 8'h00, 8'h00, 1'b1, 3);

    // Layer 3 masked off: layer 7 green wins
    en[3] = 1'b0;
    drive_pixel(rq, en, rgb, 8'h03, 1'b1, 1'b0);
    idle(1'b0);
    check_pixel("l7_wins", 8'h00, 8'hFF, 8'h00, 1'b1, 7);

    // Both masked: background blue
    en[7] = 1'b0;
    drive_pixel(rq, en, rgb, 8'h03, 1'b1, 1'b0);
    idle(1'b0);
    check_pixel("bg_only", 8'h00, 8'h00, 8'hFF, 1'b0, 0);

    // Transparent key on layer 5: background shown, no overlap recorded
    drive_pixel({NL{1'b0}}, {NL{1'b1}}, {NL*8{1'b0}}, 8'h00, 1'b0, 1'b1);
    en  = {NL{1'b1}};
    rq  = 16'h0020;
    rgb = {NL*8{1'b0}};
    rgb[5*8 +: 8] = 8'hFF;
    drive_pixel(rq, en, rgb, 8'h03, 1'b1, 1'b0);
    idle(1'b0);
    check_pixel("transparent", 8'h00, 8'h00, 8'hFF, 1'b0, 0);
    check("transparent_live", 32'(overlapLive), 32'h0);

    // Layers 2 and 9 overlap for one pixel
    rq  = 16'h0204;
    rgb = {NL*8{1'b0}};
    rgb[2*8 +: 8] = 8'h10;
    rgb[9*8 +: 8] = 8'h20;
    drive_pixel(rq, en, rgb, 8'h00, 1'b1, 1'b0);
    idle(1'b0);
    check("ovl_live_9", 32'(overlapLive), 32'h0200);
    check("ovl_live_bit2", 32'(overlapLive[2]), 32'h0);
    idle(1'b1);
    check("ovl_frame_9", 32'(overlapFrame), 32'h0200);
    check("ovl_live_clr", 32'(overlapLive), 32'h0);

    // Overlap pending in the same cycle as the frame pulse
    rq  = 16'h0011;
    rgb = {NL*8{1'b0}};
    rgb[0*8 +: 8] = 8'h40;
    rgb[4*8 +: 8] = 8'h41;
    drive_pixel(rq, en, rgb, 8'h00, 1'b1, 1'b0);
    idle(1'b1);
    check("sof_same_frame", 32'(overlapFrame), 32'h0010);
    check("sof_same_live",  32'(overlapLive),  32'h0);
    idle(1'b1);
    check("sof_back2back_frame", 32'(overlapFrame), 32'h0);
    check("sof_back2back_live",  32'(overlapLive),  32'h0);

    // Blanking with layers active
    rq  = {NL{1'b1}};
    rgb = {NL{8'h5A}};
    drive_pixel(rq, en, rgb, 8'h77, 1'b0, 1'b0);
    idle(1'b0);
    check_pixel("blanking", 8'h00, 8'h00, 8'h00, 1'b0, 0);

    // Random traffic, a mid-stream reset, more random traffic
    for (int n = 0; n < 1200; n++) rand_pixel();
    pulse_reset(3);
    next_sof = 1'b0;
    for (int n = 0; n < 800; n++) rand_pixel();

    // Let the pipeline drain and confirm every expectation was consumed
    repeat (3) @(negedge clk);
    check("sb_drain_pix", 32'(pix_q.size()), 32'h0);
    check("sb_drain_ovl", 32'(ovl_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_priority_mux.md
LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

Interface
REQ-001 Parameter NUM_LAYERS, default 16: number of drawable layers; index 0 is the highest priority; legal range 2..32.
REQ-002 Parameter TRANSPARENT_RGB, default 8'hFF: RGB332 key treated as "not drawing" even while the layer's request is high.
REQ-003 Parameter IDX_W, default $clog2(NUM_LAYERS): width of the layer index outputs.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 drawReq  input  NUM_LAYERS  per-layer drawing request for the current pixel.
REQ-007 layerRGB  input  NUM_LAYERS x 8  per-layer RGB332 colour.
REQ-008 layerEnable  input  NUM_LAYERS  per-layer enable mask; 0 hides the layer.
REQ-009 backGroundRGB  input  8  colour used when no layer qualifies.
REQ-010 pixelValid  input  1  high inside the visible area; low during blanking.
REQ-011 startOfFrame  input  1  one-cycle pulse at the first pixel of each frame.
REQ-012 redOut / greenOut / blueOut  output  8 each  expanded 24-bit colour.
REQ-013 winValid  output  1  high when the output pixel comes from a layer rather than the background.
REQ-014 winLayer  output  IDX_W  index of the winning layer; 0 when winValid is low.
REQ-015 overlapLive  output  NUM_LAYERS  sticky overlap flags for the current frame.
REQ-016 overlapFrame  output  NUM_LAYERS  overlap flags of the last completed frame.

Function
REQ-017 Layer i qualifies when drawReq[i] & layerEnable[i] & (layerRGB[i] != TRANSPARENT_RGB).
REQ-018 Stage 1 registers the qualify vector, all layerRGB, backGroundRGB and pixelValid every cycle.
REQ-019 Stage 2 selects the lowest-index qualified layer, otherwise the background, and registers the colour, winValid and winLayer.
REQ-020 Latency from inputs to outputs is exactly 2 clock cycles, with throughput of one pixel per cycle and no stalls.
REQ-021 When stage-1 pixelValid is 0, stage 2 registers colour 8'h00, winValid 0 and winLayer 0.
REQ-022 Expansion from the registered colour c: red={c[7:5],c[7:5],c[7:6]}, green={c[4:2],c[4:2],c[4:3]}, blue={c[1:0],c[1:0],c[1:0],c[1:0]}.
REQ-023 overlapLive[i] sets when stage-1 layer i qualifies while any layer j<i also qualifies, and stage-1 pixelValid is 1.
REQ-024 On startOfFrame, overlapFrame loads overlapLive, including any set pending in that same cycle.
REQ-025 On startOfFrame, overlapLive clears; the clear takes precedence over same-cycle sets.
REQ-026 Layer 0 never sets an overlap flag.
REQ-027 A layer hidden by the enable mask or the transparent key neither wins nor sets or causes overlap.
REQ-028 A startOfFrame arriving on consecutive cycles is legal; each pulse snapshots and clears.

Reset
REQ-029 While reset is high, all pipeline registers, all colour outputs, winValid, winLayer, overlapLive and overlapFrame are 0.
REQ-030 After reset deasserts, the first valid output appears 2 cycles after the first sampled input.
REQ-031 Reset asserted mid-frame discards pipeline contents and flags immediately, with no partial snapshot.

Structure
REQ-032 The shared package layer_mux_pkg holds the RGB332 field positions, the TRANSPARENT_RGB default and the layer-index constants used by the top level.
REQ-033 Lowest-index-first selection is one combinational sub-module, layer_prio_enc, with parameter NUM_LAYERS and outputs any/index.
REQ-034 No other sub-modules are used; all state lives in layer_priority_mux.

Verification
REQ-035 Layers 3 and 7 request with 8'hE0 and 8'h1C -> 2 cycles later red=8'hFF, green=0, blue=0, winLayer=3, winValid=1.
REQ-036 Layer 3 request with layerEnable[3]=0, background 8'h03 -> colour becomes layer 7's, winLayer=7; with layer 7 also off, blue=8'hFF and winValid=0.
REQ-037 Layer 5 RGB=8'hFF with request high, no other layer -> background output and overlapLive all 0.
REQ-038 Layers 2 and 9 overlap for one valid pixel -> overlapLive[9]=1 and bit 2 stays 0; at next startOfFrame overlapFrame[9]=1 and overlapLive=0.
REQ-039 Overlap occurring in the same cycle as startOfFrame -> captured in overlapFrame, overlapLive=0 afterwards.
REQ-040 pixelValid=0 with layers active -> outputs 0 two cycles later; reset pulse mid-stream -> all outputs 0 asynchronously.
